// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: widths, NOP encoding, stall limit.
// Imported by if_stage and if_stall_watchdog.
package if_stage_pkg;
  localparam int ISIZE     = 16;
  localparam int ASIZE     = 16;
  localparam int STALL_MAX = 4;
  localparam logic [15:0] NOP_INSTR = 16'h7000;
endpackage

// File: rtl/if_stall_watchdog.sv
// Saturating count of consecutive non-flush PC_En=0 cycles.
// Ports: clk, rst_n, PC_En, br_taken -> stall_err (sticky until reset).
module if_stall_watchdog
  import if_stage_pkg::*;
#(
  parameter int SMAX = STALL_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PC_En,
  input  logic br_taken,
  output logic stall_err
);
  localparam int CW = $clog2(SMAX + 1);
  localparam logic [CW-1:0] LIM = CW'(SMAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (PC_En || br_taken)
      cnt_nxt = '0;
    else if (cnt != LIM)
      cnt_nxt = cnt + CW'(1);
  end

  // Error is flagged on the same edge the count reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      stall_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (cnt_nxt == LIM)
        stall_err <= 1'b1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// Fetch stage + IF/ID register: PC, Instr, LastInstr, bubbles, flush.
// Ports: PC_En/instr_sel/br_* in, imem_*, Instr/LastInstr/id_valid out.
// Optional bubble counter: define IF_PERF_CNT_EN (else tied to 0).
module if_stage
  import if_stage_pkg::*;
#(
  parameter int ISIZE     = if_stage_pkg::ISIZE,
  parameter int ASIZE     = if_stage_pkg::ASIZE,
  parameter int STALL_MAX = if_stage_pkg::STALL_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_En,
  input  logic             instr_sel,
  input  logic             br_taken,
  input  logic [ASIZE-1:0] br_target,
  output logic [ASIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_rdata,
  output logic [ISIZE-1:0] Instr,
  output logic [ISIZE-1:0] LastInstr,
  output logic             id_valid,
  output logic             stall_err,
  output logic [15:0]      bubble_cnt
);
  localparam logic [ISIZE-1:0] NOP = ISIZE'(NOP_INSTR);

  logic [ASIZE-1:0] pc;
  logic             flush;
  logic             adv;
  logic             bub;

  assign flush = br_taken;
  assign adv   = !br_taken && PC_En;
  assign bub   = !br_taken && !PC_En && instr_sel;

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      Instr     <= NOP;
      LastInstr <= NOP;
      id_valid  <= 1'b0;
    end else begin
      unique case (1'b1)
        flush: begin
          pc        <= br_target;
          Instr     <= NOP;
          LastInstr <= NOP;
          id_valid  <= 1'b0;
        end
        adv: begin
          pc        <= pc + ASIZE'(1);
          Instr     <= imem_rdata;
          LastInstr <= Instr;
          id_valid  <= (Instr != NOP);
        end
        bub: begin
          LastInstr <= NOP;
          id_valid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= 16'd0;
    else if (bub)
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`else
  assign bubble_cnt = 16'd0;
`endif

  if_stall_watchdog #(
    .SMAX(STALL_MAX)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .PC_En    (PC_En),
    .br_taken (br_taken),
    .stall_err(stall_err)
  );
endmodule
